// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone subtract pipeline.
package ks_pkg;

  // Default operand width.
  localparam int KS_N = 16;

  // Per-stage payload: group generate, group propagate and raw bit propagate.
  typedef struct packed {
    logic [KS_N-1:0] G;
    logic [KS_N-1:0] P;
    logic [KS_N-1:0] p;
  } ks_pg_t;

  // Number of prefix levels needed to resolve every carry for width n.
  function automatic int ks_levels(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One row of Kogge-Stone black/grey cells combining each bit with the bit D below.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int N = KS_N,
  parameter int D = 1
) (
  input  logic [N-1:0] i_g,
  input  logic [N-1:0] i_p,
  output logic [N-1:0] o_g,
  output logic [N-1:0] o_p
);

  // Bits below distance D are already final and pass straight through.
  always_comb begin
    o_g = i_g;
    o_p = i_p;
    for (int i = D; i < N; i++) begin
      o_g[i] = i_g[i] | (i_p[i] & i_g[i-D]);
      o_p[i] = i_p[i] & i_p[i-D];
    end
  end

endmodule

// File: rtl/ks_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor a - b with borrow, overflow and zero flags.
// Stages: PG, L prefix levels, result. One global advance signal stalls everything.
module ks_subtractor_pipe
  import ks_pkg::*;
#(
  parameter int N = KS_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf,
  output logic         zero
);

  localparam int L = ks_levels(N);

  typedef struct packed {
    logic [N-1:0] G;
    logic [N-1:0] P;
    logic [N-1:0] p;
  } pg_t;

  logic         w_advance;
  pg_t          w_pg;
  pg_t          r_stage [0:L];
  logic         r_vld   [0:L];
  logic [N-1:0] w_lvl_g [1:L];
  logic [N-1:0] w_lvl_p [1:L];

  logic [N-1:0] w_c;
  logic [N-1:0] w_diff;
  logic         w_borrow;
  logic         w_ovf;
  logic         w_zero;
  logic         w_unused_p;

  logic [N-1:0] r_diff;
  logic         r_borrow;
  logic         r_ovf;
  logic         r_zero;
  logic         r_out_valid;

  assign w_advance = ~r_out_valid | out_ready;
  assign in_ready  = w_advance;

  // Bit generate/propagate of a + ~b, with the subtract carry-in of 1 folded into bit 0.
  always_comb begin
    w_pg.p    = a ^ ~b;
    w_pg.G    = a & ~b;
    w_pg.P    = w_pg.p;
    w_pg.G[0] = (a[0] & ~b[0]) | w_pg.p[0];
    w_pg.P[0] = 1'b0;
  end

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    ks_prefix_level #(
      .N(N),
      .D(1 << (l - 1))
    ) u_level (
      .i_g(r_stage[l-1].G),
      .i_p(r_stage[l-1].P),
      .o_g(w_lvl_g[l]),
      .o_p(w_lvl_p[l])
    );
  end

  // Data-path stage registers; contents only matter where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_stage[0] <= w_pg;
      for (int l = 1; l <= L; l++) begin
        r_stage[l].G <= w_lvl_g[l];
        r_stage[l].P <= w_lvl_p[l];
        r_stage[l].p <= r_stage[l-1].p;
      end
    end
  end

  // Per-stage valid bits; bubbles travel with the pipeline rather than being squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l <= L; l++) begin
        r_vld[l] <= 1'b0;
      end
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      for (int l = 1; l <= L; l++) begin
        r_vld[l] <= r_vld[l-1];
      end
      r_out_valid <= r_vld[L];
    end
  end

  // Carries are the resolved group generates shifted up one place, carry-in 1 at bit 0.
  always_comb begin
    w_c      = {r_stage[L].G[N-2:0], 1'b1};
    w_diff   = r_stage[L].p ^ w_c;
    w_borrow = ~r_stage[L].G[N-1];
    w_ovf    = r_stage[L].G[N-2] ^ r_stage[L].G[N-1];
    w_zero   = ~|w_diff;
  end

  // Final group propagate is not needed once all carries are known.
  assign w_unused_p = ^r_stage[L].P;

  // Result registers, cleared by reset and held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_advance) begin
      r_diff   <= w_diff;
      r_borrow <= w_borrow;
      r_ovf    <= w_ovf;
      r_zero   <= w_zero;
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Self-checking bench for ks_subtractor_pipe at N = 16.
module tb_ks_subtractor_pipe;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;

  logic [18:0] sb_q [$];
  logic        prev_stall = 1'b0;
  logic [18:0] prev_res   = '0;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] ed;
    logic        eb;
    logic        eo;
    logic        ez;
  } vec_t;

  vec_t vec [0:8];

  ks_subtractor_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: {diff, borrow, ovf, zero}
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] d;
    logic        o;
    d = x - y;
    o = (x[15] != y[15]) && (d[15] != x[15]);
    return {d, (x < y), o, (d == 16'h0000)};
  endfunction

  // One cycle: drive after negedge, sample #1 later, score the handshakes of the coming edge.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ordy, output logic acc);
    logic [18:0] cur;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    cur = {diff, borrow, ovf, zero};
    if (prev_stall) begin
      chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
      chk("stall_outputs_held", {13'd0, cur}, {13'd0, prev_res});
    end
    if (out_valid && !out_ready) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    prev_stall = out_valid && !out_ready;
    prev_res   = cur;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("result", {13'd0, cur}, {13'd0, sb_q.pop_front()});
      end
    end
    acc = iv && in_ready;
    if (acc) sb_q.push_back(model(ia, ib));
  endtask

  initial begin
    int          lat;
    int          nxt;
    int          got0;
    int          t;
    logic        acc;
    logic [15:0] sa [0:7];
    logic [15:0] sbv [0:7];

    vec[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vec[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vec[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vec[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
    vec[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    vec[5] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vec[6] = '{16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0};
    vec[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vec[8] = '{16'h1234, 16'h4321, 16'hCF13, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outputs", {13'd0, diff, borrow, ovf, zero}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time, with latency measured in edges.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vec[i].va; b = vec[i].vb; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        #1;
        lat++;
      end
      chk($sformatf("latency_v%0d", i), lat, 32'd6);
      chk($sformatf("result_v%0d", i), {13'd0, diff, borrow, ovf, zero},
          {13'd0, vec[i].ed, vec[i].eb, vec[i].eo, vec[i].ez});
    end
    @(negedge clk);

    // Eight back-to-back operations with a 3-cycle consumer stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      sa[i]  = 16'h1000 * 16'(i) + 16'h0111;
      sbv[i] = 16'h0123 * 16'(i + 3);
    end
    nxt = 0;
    t   = 0;
    while ((nxt < 8 || sb_q.size() != 0) && t < 60) begin
      cycle(nxt < 8, (nxt < 8) ? sa[nxt & 7] : 16'h0000, (nxt < 8) ? sbv[nxt & 7] : 16'h0000,
            !(t >= 7 && t <= 9), acc);
      if (acc) nxt++;
      t++;
    end
    chk("stream_all_accepted", nxt, 32'd8);
    chk("stream_drained", sb_q.size(), 32'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0100 + 16'(i), 16'h0001, 1'b1, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_outputs", {13'd0, diff, borrow, ovf, zero}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got0 = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
      if (out_valid) got0++;
    end
    chk("after_reset_no_output", got0, 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 3) != 0), acc);
    end
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
      t++;
    end
    chk("random_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
